// File: rtl/pwm_line_sequencer_pkg.sv
// Shared constants and FSM encoding for the PWM line sequencer.
// Default geometry matches the 8-stage PWM datapath it feeds.
package pwm_pkg;

    localparam int STAGE_DEF  = 8;
    localparam int DWIDTH_DEF = 8;
    localparam int LCW        = 16;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_LOAD      = 3'd1;
    localparam state_t S_WAIT_SYNC = 3'd2;
    localparam state_t S_WAIT_DONE = 3'd3;
    localparam state_t S_GAP       = 3'd4;

endpackage

// File: rtl/pwm_duty_fifo.sv
// Duty-byte queue: synchronous FIFO with occupancy count.
// Refuses pushes when full; a pop never frees space in the same cycle.
module pwm_duty_fifo #(
    parameter int DEPTH  = 16,
    parameter int DWIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    input  logic [DWIDTH-1:0] push_data,
    output logic              ready,
    input  logic              pop,
    output logic [DWIDTH-1:0] head,
    output logic [CW-1:0]     count
);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic              do_push;
    logic              do_pop;

    assign ready   = count < CW'(DEPTH);
    assign do_push = push_valid && ready;
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pwm_line_sequencer.sv
// Launches one PWM line per STAGE queued duty bytes, then waits for
// hsync and for the PWM outputs to fall before an optional blanking gap.
module pwm_line_sequencer
    import pwm_pkg::*;
#(
    parameter int STAGE   = STAGE_DEF,
    parameter int DWIDTH  = DWIDTH_DEF,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024,
    parameter int GWIDTH  = 8
) (
    input  logic              clkfordata,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_data,
    output logic              in_ready,
    input  logic [GWIDTH-1:0] gap_cycles,
    output logic              pwm_start,
    output logic [DWIDTH-1:0] pwm_data,
    input  logic              pwm_hsync,
    input  logic              pwm_busy,
    output logic              line_done,
    output logic [LCW-1:0]    line_count,
    output logic              err,
    input  logic              clr_err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int KW = (STAGE > 1) ? $clog2(STAGE) : 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    state_t            state;
    logic [KW-1:0]     k;
    logic [TW-1:0]     tcnt;
    logic [GWIDTH-1:0] gcnt;
    logic              first;

    logic [DWIDTH-1:0] head;
    logic [CW-1:0]     count;
    logic              go;
    logic              last_k;
    logic              pop;
    logic              timeout;

    assign go      = (state == S_IDLE) && en && (count >= CW'(STAGE));
    assign last_k  = k == KW'(STAGE - 1);
    assign pop     = go || ((state == S_LOAD) && !last_k);
    assign timeout = (state == S_WAIT_SYNC) && !pwm_hsync
                     && (tcnt == TW'(TIMEOUT - 1));

    pwm_duty_fifo #(
        .DEPTH  (DEPTH),
        .DWIDTH (DWIDTH)
    ) u_fifo (
        .clk        (clkfordata),
        .rst        (rst),
        .push_valid (in_valid),
        .push_data  (in_data),
        .ready      (in_ready),
        .pop        (pop),
        .head       (head),
        .count      (count)
    );

    // Output registers track the state register: LOAD cycle k shows byte k.
    always_ff @(posedge clkfordata) begin
        if (rst) begin
            state      <= S_IDLE;
            k          <= '0;
            tcnt       <= '0;
            gcnt       <= '0;
            first      <= 1'b0;
            pwm_start  <= 1'b0;
            pwm_data   <= '0;
            line_done  <= 1'b0;
            line_count <= '0;
            err        <= 1'b0;
        end else begin
            pwm_start <= 1'b0;
            pwm_data  <= '0;
            line_done <= 1'b0;

            if (timeout) begin
                err <= 1'b1;
            end else if (clr_err) begin
                err <= 1'b0;
            end

            unique case (state)
                S_IDLE: begin
                    if (go) begin
                        state     <= S_LOAD;
                        k         <= '0;
                        pwm_start <= 1'b1;
                        pwm_data  <= head;
                    end
                end
                S_LOAD: begin
                    if (last_k) begin
                        state <= S_WAIT_SYNC;
                        tcnt  <= '0;
                    end else begin
                        k        <= k + KW'(1);
                        pwm_data <= head;
                    end
                end
                S_WAIT_SYNC: begin
                    if (pwm_hsync) begin
                        state <= S_WAIT_DONE;
                        first <= 1'b1;
                    end else if (timeout) begin
                        state <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_WAIT_DONE: begin
                    // busy may still reflect the previous line on entry
                    if (first) begin
                        first <= 1'b0;
                    end else if (!pwm_busy) begin
                        state      <= S_GAP;
                        gcnt       <= gap_cycles;
                        line_done  <= 1'b1;
                        line_count <= line_count + LCW'(1);
                    end
                end
                S_GAP: begin
                    if (gcnt <= GWIDTH'(1)) begin
                        state <= S_IDLE;
                    end else begin
                        gcnt <= gcnt - GWIDTH'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_line_sequencer.sv
// Directed self-checking bench for pwm_line_sequencer.
module tb_pwm_line_sequencer;

    logic        clkfordata = 1'b0;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [7:0]  gap_cycles;
    logic        pwm_start;
    logic [7:0]  pwm_data;
    logic        pwm_hsync;
    logic        pwm_busy;
    logic        line_done;
    logic [15:0] line_count;
    logic        err;
    logic        clr_err;

    int checks = 0;
    int errors = 0;

    always #5 clkfordata = ~clkfordata;

    pwm_line_sequencer dut (
        .clkfordata (clkfordata),
        .rst        (rst),
        .en         (en),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .gap_cycles (gap_cycles),
        .pwm_start  (pwm_start),
        .pwm_data   (pwm_data),
        .pwm_hsync  (pwm_hsync),
        .pwm_busy   (pwm_busy),
        .line_done  (line_done),
        .line_count (line_count),
        .err        (err),
        .clr_err    (clr_err)
    );

    task automatic tick();
        @(posedge clkfordata);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int ndone;
        int dcyc;
        int scyc;
        int n;
        int starts;

        rst        = 1'b1;
        en         = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        gap_cycles = 8'd4;
        pwm_hsync  = 1'b0;
        pwm_busy   = 1'b0;
        clr_err    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_start", 32'(pwm_start), 32'd0);
        check("rst_data", 32'(pwm_data), 32'd0);
        check("rst_count", 32'(line_count), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_done", 32'(line_done), 32'd0);

        // line 1: 0x10..0x17
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h10 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        en = 1'b1;
        tick();
        check("l1_start", 32'(pwm_start), 32'd1);
        check("l1_d0", 32'(pwm_data), 32'h10);
        // queue line 2 while line 1 streams out
        for (int i = 1; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h20 + 8'(i - 1);
            tick();
            check("l1_start_lo", 32'(pwm_start), 32'd0);
            check("l1_data", 32'(pwm_data), 32'h10 + 32'(i));
            check("l1_in_ready", 32'(in_ready), 32'd1);
        end
        in_data = 8'h27;
        tick();
        in_valid = 1'b0;
        check("l1_end_data", 32'(pwm_data), 32'd0);
        tick();
        tick();
        pwm_hsync = 1'b1;
        pwm_busy  = 1'b1;
        tick();
        pwm_hsync = 1'b0;
        ndone = 0;
        dcyc  = -1;
        scyc  = -1;
        for (int c = 0; c < 60; c++) begin
            if (c == 4) pwm_busy = 1'b0;
            tick();
            if (line_done) begin
                ndone++;
                dcyc = c;
            end
            if (pwm_start) begin
                scyc = c;
                break;
            end
        end
        check("l1_done_once", 32'(ndone), 32'd1);
        check("l1_count", 32'(line_count), 32'd1);
        check("l2_spacing", 32'(scyc - dcyc), 32'd5);
        check("l2_d0", 32'(pwm_data), 32'h20);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("l2_data", 32'(pwm_data), 32'h20 + 32'(i));
        end

        // line 2 sees no hsync: timeout
        n = 0;
        starts = 0;
        while (!err && n < 1100) begin
            tick();
            n++;
            if (pwm_start) starts++;
        end
        check("to_cycles", 32'(n), 32'd1025);
        check("to_err", 32'(err), 32'd1);
        check("to_count", 32'(line_count), 32'd1);
        check("to_no_start", 32'(starts), 32'd0);
        check("to_no_done", 32'(line_done), 32'd0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr_err", 32'(err), 32'd0);

        // fill queue while disabled
        en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h30 + 8'(i);
            tick();
        end
        check("full_ready", 32'(in_ready), 32'd0);
        in_data = 8'hEE;
        tick();
        in_valid = 1'b0;
        check("full_drop_ready", 32'(in_ready), 32'd0);
        en = 1'b1;
        tick();
        check("l3_start", 32'(pwm_start), 32'd1);
        check("l3_d0", 32'(pwm_data), 32'h30);
        check("l3_ready", 32'(in_ready), 32'd1);
        en = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            check("l3_data", 32'(pwm_data), 32'h30 + 32'(i));
        end
        tick();
        pwm_hsync = 1'b1;
        tick();
        pwm_hsync = 1'b0;
        tick();
        tick();
        check("l3_done", 32'(line_done), 32'd1);
        check("l3_count", 32'(line_count), 32'd2);

        // remaining 8 must be 0x38..0x3F, 0xEE dropped
        gap_cycles = 8'd0;
        en = 1'b1;
        n = 0;
        while (!pwm_start && n < 10) begin
            tick();
            n++;
        end
        check("l4_start", 32'(pwm_start), 32'd1);
        check("l4_d0", 32'(pwm_data), 32'h38);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("l4_data", 32'(pwm_data), 32'h38 + 32'(i));
        end
        tick();
        pwm_hsync = 1'b1;
        tick();
        pwm_hsync = 1'b0;
        tick();
        tick();
        check("l4_count", 32'(line_count), 32'd3);
        starts = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (pwm_start) starts++;
        end
        check("l4_no_extra", 32'(starts), 32'd0);

        // partial line must not launch
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h40 + 8'(i);
            tick();
            if (pwm_start) starts++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (pwm_start) starts++;
        end
        check("p7_no_start", 32'(starts), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h47;
        tick();
        in_valid = 1'b0;
        check("p8_push_cycle", 32'(pwm_start), 32'd0);
        tick();
        check("p8_start", 32'(pwm_start), 32'd1);
        check("p8_d0", 32'(pwm_data), 32'h40);
        tick();
        tick();
        tick();
        check("p8_d3", 32'(pwm_data), 32'h43);

        // reset mid-line
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_start", 32'(pwm_start), 32'd0);
        check("mr_data", 32'(pwm_data), 32'd0);
        check("mr_count", 32'(line_count), 32'd0);
        check("mr_ready", 32'(in_ready), 32'd1);
        starts = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (pwm_start) starts++;
        end
        check("mr_empty", 32'(starts), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
